// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and write-back source select for the 5-stage MIPS core.
// Optional retire/stall performance counters are enabled by defining WB_PERF_CNT_EN.
module mem_wb_stage #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_MEM,
   input  logic                  flush,
   input  logic                  mem_stall,
   input  logic                  RegWrite_MEM,
   input  logic [1:0]            MemtoReg_MEM,
   input  logic [REG_ADDR_W-1:0] WriteReg_MEM,
   input  logic [DATA_W-1:0]     ALUres_MEM,
   input  logic [DATA_W-1:0]     MemRd,
   input  logic [DATA_W-1:0]     ExtImm_MEM,
   input  logic [DATA_W-1:0]     PC8_MEM,
   output logic [DATA_W-1:0]     ALUres_WB,
   output logic [DATA_W-1:0]     MemRd_WB,
   output logic [DATA_W-1:0]     ExtImm_WB,
   output logic [REG_ADDR_W-1:0] WriteReg_WB,
   output logic                  RegWrite_WB,
   output logic [DATA_W-1:0]     WriteData_WB,
   output logic                  valid_WB,
   output logic [CNT_W-1:0]      retire_cnt,
   output logic [CNT_W-1:0]      stall_cnt
);

   logic [DATA_W-1:0]     alu_q;
   logic [DATA_W-1:0]     memrd_q;
   logic [DATA_W-1:0]     extimm_q;
   logic [DATA_W-1:0]     pc8_q;
   logic [REG_ADDR_W-1:0] wreg_q;
   logic [1:0]            memtoreg_q;
   logic                  regwrite_q;
   logic                  valid_q;

   // flush and stall both insert a bubble; fields hold so forwarding stays stable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_q      <= '0;
         memrd_q    <= '0;
         extimm_q   <= '0;
         pc8_q      <= '0;
         wreg_q     <= '0;
         memtoreg_q <= '0;
         regwrite_q <= 1'b0;
         valid_q    <= 1'b0;
      end else if (flush || mem_stall) begin
         valid_q <= 1'b0;
      end else begin
         alu_q      <= ALUres_MEM;
         memrd_q    <= MemRd;
         extimm_q   <= ExtImm_MEM;
         pc8_q      <= PC8_MEM;
         wreg_q     <= WriteReg_MEM;
         memtoreg_q <= MemtoReg_MEM;
         regwrite_q <= RegWrite_MEM;
         valid_q    <= valid_MEM;
      end
   end

   always_comb begin
      WriteData_WB = alu_q;
      unique case (memtoreg_q)
         2'd0: WriteData_WB = alu_q;
         2'd1: WriteData_WB = memrd_q;
         2'd2: WriteData_WB = extimm_q;
         2'd3: WriteData_WB = pc8_q;
         default: WriteData_WB = alu_q;
      endcase
   end

   assign ALUres_WB   = alu_q;
   assign MemRd_WB    = memrd_q;
   assign ExtImm_WB   = extimm_q;
   assign WriteReg_WB = wreg_q;
   assign valid_WB    = valid_q;
   assign RegWrite_WB = valid_q & regwrite_q;

`ifdef WB_PERF_CNT_EN
   logic [CNT_W-1:0] retire_q;
   logic [CNT_W-1:0] stall_q;

   // saturating counters, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_q <= '0;
         stall_q  <= '0;
      end else begin
         if (valid_q && (retire_q != '1))
            retire_q <= retire_q + CNT_W'(1);
         if (mem_stall && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
      end
   end

   assign retire_cnt = retire_q;
   assign stall_cnt  = stall_q;
`else
   assign retire_cnt = '0;
   assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; counter checks follow WB_PERF_CNT_EN.
module tb_mem_wb_stage;

   logic        clk;
   logic        rst;
   logic        valid_MEM;
   logic        flush;
   logic        mem_stall;
   logic        RegWrite_MEM;
   logic [1:0]  MemtoReg_MEM;
   logic [4:0]  WriteReg_MEM;
   logic [31:0] ALUres_MEM;
   logic [31:0] MemRd;
   logic [31:0] ExtImm_MEM;
   logic [31:0] PC8_MEM;
   logic [31:0] ALUres_WB;
   logic [31:0] MemRd_WB;
   logic [31:0] ExtImm_WB;
   logic [4:0]  WriteReg_WB;
   logic        RegWrite_WB;
   logic [31:0] WriteData_WB;
   logic        valid_WB;
   logic [31:0] retire_cnt;
   logic [31:0] stall_cnt;

   int unsigned passed;
   int unsigned total;

   mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .valid_MEM(valid_MEM), .flush(flush), .mem_stall(mem_stall),
      .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM), .WriteReg_MEM(WriteReg_MEM),
      .ALUres_MEM(ALUres_MEM), .MemRd(MemRd), .ExtImm_MEM(ExtImm_MEM), .PC8_MEM(PC8_MEM),
      .ALUres_WB(ALUres_WB), .MemRd_WB(MemRd_WB), .ExtImm_WB(ExtImm_WB),
      .WriteReg_WB(WriteReg_WB), .RegWrite_WB(RegWrite_WB), .WriteData_WB(WriteData_WB),
      .valid_WB(valid_WB), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic v, input logic rw, input logic [1:0] m2r,
                            input logic [4:0] wr, input logic [31:0] alu);
      valid_MEM    = v;
      RegWrite_MEM = rw;
      MemtoReg_MEM = m2r;
      WriteReg_MEM = wr;
      ALUres_MEM   = alu;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; mem_stall = 1'b0;
      set_instr(1'b1, 1'b1, 2'd3, 5'd9, 32'hFFFF_FFFF);
      MemRd = 32'h1111_1111; ExtImm_MEM = 32'h2222_2222; PC8_MEM = 32'h3333_3333;
      tick(); tick();
      total++; if (valid_WB !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_WB); else passed++;
      total++; if (RegWrite_WB !== 1'b0) $display("FAIL reset_regwrite: got %b expected 0", RegWrite_WB); else passed++;
      total++; if (WriteData_WB !== 32'h0) $display("FAIL reset_wdata: got %h expected 0", WriteData_WB); else passed++;
      total++; if ({ALUres_WB, MemRd_WB, ExtImm_WB} !== 96'h0) $display("FAIL reset_data: got %h %h %h expected 0", ALUres_WB, MemRd_WB, ExtImm_WB); else passed++;
      total++; if (WriteReg_WB !== 5'd0) $display("FAIL reset_wreg: got %0d expected 0", WriteReg_WB); else passed++;
      total++; if ({retire_cnt, stall_cnt} !== 64'h0) $display("FAIL reset_cnt: got %0d %0d expected 0 0", retire_cnt, stall_cnt); else passed++;
      rst = 1'b0;
      set_instr(1'b0, 1'b0, 2'd0, 5'd0, 32'h0);
      MemRd = 32'h0; ExtImm_MEM = 32'h0; PC8_MEM = 32'h0;
   endtask

   task automatic test_alu();
      set_instr(1'b1, 1'b1, 2'd0, 5'd5, 32'h0000_1234);
      tick();
      total++; if (RegWrite_WB !== 1'b1) $display("FAIL alu_regwrite: got %b expected 1", RegWrite_WB); else passed++;
      total++; if (WriteReg_WB !== 5'd5) $display("FAIL alu_wreg: got %0d expected 5", WriteReg_WB); else passed++;
      total++; if (WriteData_WB !== 32'h0000_1234) $display("FAIL alu_wdata: got %h expected 00001234", WriteData_WB); else passed++;
      valid_MEM = 1'b0;
      tick();
      total++; if (valid_WB !== 1'b0) $display("FAIL alu_bubble_valid: got %b expected 0", valid_WB); else passed++;
      total++; if (RegWrite_WB !== 1'b0) $display("FAIL alu_bubble_regwrite: got %b expected 0", RegWrite_WB); else passed++;
   endtask

   task automatic test_load_stall();
      int unsigned writes;
      writes = 0;
      set_instr(1'b1, 1'b1, 2'd1, 5'd7, 32'h0000_0040);
      MemRd = 32'h5555_5555;
      mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (RegWrite_WB !== 1'b0) $display("FAIL stall_regwrite[%0d]: got %b expected 0", i, RegWrite_WB); else passed++;
      end
      total++; if (MemRd_WB !== 32'h0) $display("FAIL stall_memrd_hold: got %h expected 00000000", MemRd_WB); else passed++;
      MemRd = 32'hDEAD_BEEF;
      mem_stall = 1'b0;
      tick();
      if (RegWrite_WB === 1'b1) writes++;
      total++; if (WriteData_WB !== 32'hDEAD_BEEF) $display("FAIL load_wdata: got %h expected deadbeef", WriteData_WB); else passed++;
      total++; if (WriteReg_WB !== 5'd7) $display("FAIL load_wreg: got %0d expected 7", WriteReg_WB); else passed++;
      valid_MEM = 1'b0;
      MemRd = 32'h0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (RegWrite_WB === 1'b1) writes++;
      end
      total++; if (writes !== 1) $display("FAIL load_write_count: got %0d expected 1", writes); else passed++;
   endtask

   task automatic test_fwd_hold();
      int unsigned writes;
      set_instr(1'b1, 1'b1, 2'd0, 5'd3, 32'h0000_A5A5);
      tick();
      writes = (RegWrite_WB === 1'b1) ? 1 : 0;
      set_instr(1'b1, 1'b0, 2'd0, 5'd4, 32'h0000_FFFF);
      mem_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (RegWrite_WB === 1'b1) writes++;
         total++; if (ALUres_WB !== 32'h0000_A5A5) $display("FAIL fwd_hold[%0d]: got %h expected 0000a5a5", i, ALUres_WB); else passed++;
      end
      total++; if (writes !== 1) $display("FAIL fwd_write_count: got %0d expected 1", writes); else passed++;
      mem_stall = 1'b0;
      valid_MEM = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      set_instr(1'b0, 1'b0, 2'd0, 5'd2, 32'h0000_0BAD);
      tick();
      set_instr(1'b1, 1'b1, 2'd0, 5'd12, 32'h0000_7777);
      flush = 1'b1;
      tick();
      total++; if (valid_WB !== 1'b0) $display("FAIL flush_valid: got %b expected 0", valid_WB); else passed++;
      total++; if (RegWrite_WB !== 1'b0) $display("FAIL flush_regwrite: got %b expected 0", RegWrite_WB); else passed++;
      total++; if (ALUres_WB !== 32'h0000_0BAD) $display("FAIL flush_data_hold: got %h expected 00000bad", ALUres_WB); else passed++;
      total++; if (WriteReg_WB !== 5'd2) $display("FAIL flush_wreg_hold: got %0d expected 2", WriteReg_WB); else passed++;
      mem_stall = 1'b1;
      tick();
      total++; if ({valid_WB, RegWrite_WB} !== 2'b00) $display("FAIL flush_stall_bubble: got %b expected 00", {valid_WB, RegWrite_WB}); else passed++;
      total++; if (ALUres_WB !== 32'h0000_0BAD) $display("FAIL flush_stall_hold: got %h expected 00000bad", ALUres_WB); else passed++;
      flush = 1'b0;
      mem_stall = 1'b0;
      valid_MEM = 1'b0;
   endtask

   task automatic test_wb_mux();
      set_instr(1'b1, 1'b1, 2'd2, 5'd8, 32'h0000_0001);
      ExtImm_MEM = 32'h0040_0000;
      PC8_MEM = 32'h0000_0002;
      tick();
      total++; if (WriteData_WB !== 32'h0040_0000) $display("FAIL mux_extimm: got %h expected 00400000", WriteData_WB); else passed++;
      total++; if (ExtImm_WB !== 32'h0040_0000) $display("FAIL extimm_reg: got %h expected 00400000", ExtImm_WB); else passed++;
      set_instr(1'b1, 1'b1, 2'd3, 5'd31, 32'h0000_0001);
      PC8_MEM = 32'h0000_3008;
      tick();
      total++; if (WriteData_WB !== 32'h0000_3008) $display("FAIL mux_pc8: got %h expected 00003008", WriteData_WB); else passed++;
      total++; if ({RegWrite_WB, WriteReg_WB} !== {1'b1, 5'd31}) $display("FAIL mux_pc8_wreg: got %b/%0d expected 1/31", RegWrite_WB, WriteReg_WB); else passed++;
      valid_MEM = 1'b0;
      tick();
   endtask

   task automatic test_rst_mid_stall();
      set_instr(1'b1, 1'b1, 2'd0, 5'd6, 32'h0000_CAFE);
      tick();
      set_instr(1'b1, 1'b1, 2'd1, 5'd10, 32'h0000_0010);
      mem_stall = 1'b1;
      tick();
      #2;
      rst = 1'b1;
      #1;
      total++; if (ALUres_WB !== 32'h0) $display("FAIL rst_async_alu: got %h expected 00000000", ALUres_WB); else passed++;
      total++; if ({valid_WB, RegWrite_WB, WriteReg_WB} !== 7'h0) $display("FAIL rst_async_ctrl: got %b expected 0", {valid_WB, RegWrite_WB, WriteReg_WB}); else passed++;
      tick();
      rst = 1'b0;
      mem_stall = 1'b0;
      valid_MEM = 1'b0;
      tick();
      total++; if (RegWrite_WB !== 1'b0) $display("FAIL rst_no_retire: got %b expected 0", RegWrite_WB); else passed++;
   endtask

   task automatic test_counters();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_instr(1'b1, 1'b1, 2'd0, 5'd1, 32'h0000_0001);
      for (int i = 0; i < 10; i++) tick();
      valid_MEM = 1'b0;
      mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      mem_stall = 1'b0;
      tick();
      tick();
`ifdef WB_PERF_CNT_EN
      total++; if (retire_cnt !== 32'd10) $display("FAIL retire_cnt: got %0d expected 10", retire_cnt); else passed++;
      total++; if (stall_cnt !== 32'd3) $display("FAIL stall_cnt: got %0d expected 3", stall_cnt); else passed++;
`else
      total++; if (retire_cnt !== 32'd0) $display("FAIL retire_cnt: got %0d expected 0", retire_cnt); else passed++;
      total++; if (stall_cnt !== 32'd0) $display("FAIL stall_cnt: got %0d expected 0", stall_cnt); else passed++;
`endif
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_alu();
      test_load_stall();
      test_fwd_hold();
      test_flush();
      test_wb_mux();
      test_rst_mid_stall();
      test_counters();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
